// File: rtl/mips_fetch_unit.sv
// Decoupled MIPS32 instruction-fetch front end: credit-limited requests to an in-order
// instruction memory, a {pc, instr} prefetch queue toward decode, and redirect flushing.
`default_nettype none

module mips_fetch_unit #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [DATA_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW:0]    C_DEPTH = (CW+1)'(DEPTH);

    logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     occ_q, occ_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];

    logic              accept;
    logic              push;
    logic              pop;
    logic              drop;
    logic [CW:0]       credit_used;
    logic [DATA_W-1:0] redirect_aligned;

    // Queued plus outstanding words never exceed DEPTH, so every response has a slot.
    assign credit_used      = {1'b0, occ_q} + {1'b0, inflight_q};
    assign imem_req_valid   = (credit_used < C_DEPTH) && !redirect_valid && !reset;
    assign imem_req_addr    = fetch_pc_q;
    assign redirect_aligned = redirect_pc & ~DATA_W'(3);

    assign out_valid = (occ_q != '0);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = instr_mem_q[rd_ptr_q];

    always_comb begin
        accept     = imem_req_valid && imem_req_ready;
        pop        = out_valid && out_ready;
        drop       = (discard_q != '0);
        push       = imem_resp_valid && !drop && !redirect_valid;

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = inflight_q + CW'(accept) - CW'(imem_resp_valid);
        occ_d      = occ_q + CW'(push) - CW'(pop);

        if (accept) begin
            fetch_pc_d = fetch_pc_q + DATA_W'(4);
        end
        if (imem_resp_valid && drop) begin
            discard_d = discard_q - CW'(1);
        end
        if (push) begin
            wr_ptr_d  = wr_ptr_q + AW'(1);
            resp_pc_d = resp_pc_q + DATA_W'(4);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        // Everything still outstanding after this cycle belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            occ_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            discard_d  = inflight_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            occ_q      <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_resp_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: in-order memory model, expected {pc, instr} queue
// with epoch tags so that words fetched before a redirect or reset are expected to vanish.
`default_nettype none

module tb_mips_fetch_unit;

    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    mips_fetch_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int ep; } req_t;
    req_t        pend[$];
    logic [63:0] expq[$];

    int          n_chk = 0, n_pass = 0, epoch = 0, n_acc = 0, n_pop = 0;
    logic [31:0] exp_fetch_pc = RESET_PC, last_acc_addr = '0, last_pop_pc = '0, addr0;
    bit          ctl_ready = 0, ctl_resp = 0, ctl_ordy = 0, ctl_rd = 0;
    logic [31:0] ctl_rdpc = '0;
    int          p0, a0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    endtask

    // One clock cycle: drive at negedge, check and update the model 1 ns later.
    task automatic step();
        bit          resp_now, rd;
        req_t        r;
        logic [63:0] e;
        @(negedge clk);
        rd              = ctl_rd;
        redirect_valid  = rd;
        redirect_pc     = ctl_rdpc;
        out_ready       = ctl_ordy;
        imem_req_ready  = ctl_ready;
        resp_now        = ctl_resp && (pend.size() > 0);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? mem_word(pend[0].addr) : 32'h0;
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(expq.size() != 0));
        check_eq("req_valid", 32'(imem_req_valid),
                 32'(((expq.size() + pend.size()) < DEPTH) && !rd));
        if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_fetch_pc);
        if (out_valid && out_ready) begin
            n_pop++;
            last_pop_pc = out_pc;
            if (expq.size() == 0) begin
                check_eq("pop_with_empty_model", 32'(expq.size()), 32'd1);
            end else begin
                e = expq.pop_front();
                check_eq("out_pc", out_pc, e[63:32]);
                check_eq("out_instr", out_instr, e[31:0]);
            end
        end
        if (rd) begin
            expq.delete();
            epoch++;
            exp_fetch_pc = ctl_rdpc & ~32'h3;
        end
        if (resp_now) begin
            r = pend.pop_front();
            if (r.ep == epoch) expq.push_back({r.addr, mem_word(r.addr)});
        end
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{imem_req_addr, epoch});
            last_acc_addr = imem_req_addr;
            n_acc++;
            exp_fetch_pc += 32'd4;
        end
        ctl_rd = 0;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        out_ready       = 1'b0;
        imem_req_ready  = 1'b0;
        pend.delete();
        expq.delete();
        epoch++;
        exp_fetch_pc = RESET_PC;
        ctl_ready = 0; ctl_resp = 0; ctl_ordy = 0; ctl_rd = 0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        reset = 1'b0;
    endtask

    task automatic run_until_pop(input string tag, input logic [31:0] want);
        int start = n_pop;
        for (int i = 0; i < 30 && n_pop == start; i++) step();
        check_eq({tag, "_seen"}, 32'(n_pop - start), 32'd1);
        check_eq(tag, last_pop_pc, want);
    endtask

    task automatic run_until_acc(input string tag, input logic [31:0] want);
        int start = n_acc;
        for (int i = 0; i < 30 && n_acc == start; i++) step();
        check_eq({tag, "_seen"}, 32'(n_acc - start), 32'd1);
        check_eq(tag, last_acc_addr, want);
    endtask

    initial begin
        // Streaming with one-cycle memory and an always-ready consumer.
        do_reset();
        ctl_ready = 1; ctl_resp = 1; ctl_ordy = 1;
        run_until_pop("t1_first_pc", RESET_PC);
        p0 = n_pop;
        repeat (8) step();
        check_eq("t1_rate", 32'(n_pop - p0), 32'd8);

        // Stalled consumer: credit limit caps requests at DEPTH.
        do_reset();
        ctl_ready = 1; ctl_resp = 1; ctl_ordy = 0;
        a0 = n_acc;
        repeat (10) step();
        check_eq("t2_acc_count", 32'(n_acc - a0), 32'd4);
        check_eq("t2_req_blocked", 32'(imem_req_valid), 32'd0);
        ctl_ordy = 1;
        run_until_pop("t2_first_pc", 32'h0);
        run_until_acc("t2_resume_addr", 32'h10);
        repeat (6) step();

        // Memory back-pressure: request holds steady.
        ctl_ready = 0;
        step();
        addr0 = imem_req_addr;
        a0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t5_req_valid", 32'(imem_req_valid), 32'd1);
            check_eq("t5_addr_stable", imem_req_addr, addr0);
        end
        check_eq("t5_no_accept", 32'(n_acc - a0), 32'd0);
        ctl_ready = 1;
        run_until_acc("t5_resume_addr", addr0);

        // Redirect with two queued words and two in flight.
        do_reset();
        ctl_ready = 1; ctl_resp = 1; ctl_ordy = 0;
        repeat (3) step();
        ctl_resp = 0;
        step();
        check_eq("t3_pre_valid", 32'(out_valid), 32'd1);
        ctl_rd = 1; ctl_rdpc = 32'h100;
        step();
        ctl_resp = 1; ctl_ordy = 1;
        step();
        check_eq("t3_flushed", 32'(out_valid), 32'd0);
        run_until_pop("t3_next_pc", 32'h100);

        // Redirect, response and pop in the same cycle; unaligned target.
        do_reset();
        ctl_ready = 1; ctl_resp = 0; ctl_ordy = 0;
        repeat (2) step();
        ctl_resp = 1;
        step();
        ctl_ordy = 1; ctl_rd = 1; ctl_rdpc = 32'h203;
        p0 = n_pop;
        step();
        check_eq("t4_pop_in_redirect", 32'(n_pop - p0), 32'd1);
        check_eq("t4_popped_pc", last_pop_pc, 32'h0);
        run_until_acc("t4_next_req", 32'h200);
        run_until_pop("t4_next_pc", 32'h200);

        // Asynchronous reset mid-stream.
        do_reset();
        ctl_ready = 1; ctl_resp = 1; ctl_ordy = 0;
        repeat (3) step();
        ctl_resp = 0;
        step();
        check_eq("t6_pre_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_async_out_valid", 32'(out_valid), 32'd0);
        check_eq("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
        do_reset();
        ctl_ready = 1; ctl_resp = 1; ctl_ordy = 1;
        run_until_pop("t6_first_pc", RESET_PC);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
